// File: rtl/csr_sequencer.sv
// ==========================================================================
// csr_sequencer : Zicsr read-modify-write, trap-entry and MRET sequencer.
// Option macro CSR_VECTORED_MTVEC_EN enables vectored mtvec redirect. Rev 1.0
// ==========================================================================
`default_nettype none

module csr_sequencer #(
   parameter int RST_PC_ALIGN = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_funct3,
   input  logic [11:0] req_addr,
   input  logic [31:0] req_src,
   input  logic        req_src_idx_zero,
   input  logic        trap_req,
   input  logic [31:0] trap_pc,
   input  logic [31:0] trap_cause,
   input  logic [31:0] trap_tval,
   input  logic        mret_req,
   output logic [11:0] csr_addr,
   input  logic [31:0] csr_out,
   output logic [11:0] csr_wr_addr,
   output logic [31:0] csr_data_in,
   output logic        wr_csr_n,
   output logic [31:0] rd_data,
   output logic        rd_valid,
   output logic        illegal_csr,
   output logic [31:0] redirect_pc,
   output logic        redirect_valid
);

   localparam logic [3:0] c_ST_IDLE    = 4'd0;
   localparam logic [3:0] c_ST_C_RD    = 4'd1;
   localparam logic [3:0] c_ST_C_WR    = 4'd2;
   localparam logic [3:0] c_ST_T_EPC   = 4'd3;
   localparam logic [3:0] c_ST_T_CAUSE = 4'd4;
   localparam logic [3:0] c_ST_T_TVAL  = 4'd5;
   localparam logic [3:0] c_ST_T_STAT  = 4'd6;
   localparam logic [3:0] c_ST_M_STAT  = 4'd7;
   localparam logic [3:0] c_ST_M_EPC   = 4'd8;
   localparam logic [3:0] c_ST_M_WR    = 4'd9;

   localparam logic [11:0] c_MSTATUS = 12'h300;
   localparam logic [11:0] c_MTVEC   = 12'h305;
   localparam logic [11:0] c_MEPC    = 12'h341;
   localparam logic [11:0] c_MCAUSE  = 12'h342;
   localparam logic [11:0] c_MTVAL   = 12'h343;

   localparam logic [31:0] c_ALIGN_MASK = ~((32'd1 << RST_PC_ALIGN) - 32'd1);

   logic [3:0]  r_state;
   logic [3:0]  w_next_state;

   logic [2:0]  r_funct3;
   logic [11:0] r_addr;
   logic [31:0] r_src;
   logic        r_idx_zero;
   logic [31:0] r_old;
   logic [31:0] r_pc;
   logic [31:0] r_cause;
   logic [31:0] r_tval;
   logic [31:0] r_tvec;
   logic [31:0] r_st;
   logic [31:0] r_epc;
   logic [31:0] r_rd_data;
   logic        r_rd_valid;
   logic        r_illegal;
   logic [31:0] r_redirect_pc;
   logic        r_redirect_valid;

   logic        w_idle;
   logic        w_take_trap;
   logic        w_take_mret;
   logic        w_take_req;
   logic        w_suppress;
   logic        w_illegal;
   logic        w_do_write;
   logic [31:0] w_new;
   logic [31:0] w_trap_mstatus;
   logic [31:0] w_mret_mstatus;
   logic [31:0] w_trap_base;
   logic [31:0] w_trap_target;

   // A level-held trap/mret request is still visible during its own redirect
   // pulse; it must not be re-accepted in that cycle.
   assign w_idle      = (r_state == c_ST_IDLE);
   assign w_take_trap = w_idle & trap_req & ~r_redirect_valid;
   assign w_take_mret = w_idle & ~trap_req & mret_req & ~r_redirect_valid;
   assign w_take_req  = w_idle & ~trap_req & ~mret_req & req_valid;

   assign req_ready      = w_idle & ~trap_req & ~mret_req;
   assign rd_data        = r_rd_data;
   assign rd_valid       = r_rd_valid;
   assign illegal_csr    = r_illegal;
   assign redirect_pc    = r_redirect_pc;
   assign redirect_valid = r_redirect_valid;

   always_comb begin
      w_suppress = 1'b1;
      w_new      = r_old;
      case (r_funct3)
         3'b001, 3'b101: begin
            w_suppress = 1'b0;
            w_new      = r_src;
         end
         3'b010, 3'b110: begin
            w_suppress = r_idx_zero;
            w_new      = r_old | r_src;
         end
         3'b011, 3'b111: begin
            w_suppress = r_idx_zero;
            w_new      = r_old & ~r_src;
         end
         default: begin
            w_suppress = 1'b1;
            w_new      = r_old;
         end
      endcase
   end

   assign w_illegal  = ~w_suppress & (r_addr[11:10] == 2'b11);
   assign w_do_write = ~w_suppress & ~w_illegal;

   always_comb begin
      w_trap_mstatus        = r_st;
      w_trap_mstatus[7]     = r_st[3];
      w_trap_mstatus[3]     = 1'b0;
      w_trap_mstatus[12:11] = 2'b11;
      w_mret_mstatus        = r_st;
      w_mret_mstatus[3]     = r_st[7];
      w_mret_mstatus[7]     = 1'b1;
      w_mret_mstatus[12:11] = 2'b11;
   end

   always_comb begin
      w_trap_base = r_tvec & 32'hFFFF_FFFC;
`ifdef CSR_VECTORED_MTVEC_EN
      if ((r_tvec[1:0] == 2'b01) && r_cause[31]) begin
         w_trap_target = w_trap_base + {r_cause[29:0], 2'b00};
      end else begin
         w_trap_target = w_trap_base;
      end
`else
      w_trap_target = w_trap_base;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_ST_IDLE: begin
            if (w_take_trap) begin
               w_next_state = c_ST_T_EPC;
            end else if (w_take_mret) begin
               w_next_state = c_ST_M_STAT;
            end else if (w_take_req) begin
               w_next_state = c_ST_C_RD;
            end
         end
         c_ST_C_RD:    w_next_state = c_ST_C_WR;
         c_ST_C_WR:    w_next_state = c_ST_IDLE;
         c_ST_T_EPC:   w_next_state = c_ST_T_CAUSE;
         c_ST_T_CAUSE: w_next_state = c_ST_T_TVAL;
         c_ST_T_TVAL:  w_next_state = c_ST_T_STAT;
         c_ST_T_STAT:  w_next_state = c_ST_IDLE;
         c_ST_M_STAT:  w_next_state = c_ST_M_EPC;
         c_ST_M_EPC:   w_next_state = c_ST_M_WR;
         c_ST_M_WR:    w_next_state = c_ST_IDLE;
         default:      w_next_state = c_ST_IDLE;
      endcase
   end

   always_comb begin
      csr_addr    = 12'h000;
      csr_wr_addr = 12'h000;
      csr_data_in = 32'h0000_0000;
      wr_csr_n    = 1'b1;
      case (r_state)
         c_ST_C_RD: begin
            csr_addr = r_addr;
         end
         c_ST_C_WR: begin
            if (w_do_write) begin
               wr_csr_n    = 1'b0;
               csr_wr_addr = r_addr;
               csr_data_in = w_new;
            end
         end
         c_ST_T_EPC: begin
            csr_addr    = c_MTVEC;
            wr_csr_n    = 1'b0;
            csr_wr_addr = c_MEPC;
            csr_data_in = r_pc & 32'hFFFF_FFFC;
         end
         c_ST_T_CAUSE: begin
            csr_addr    = c_MSTATUS;
            wr_csr_n    = 1'b0;
            csr_wr_addr = c_MCAUSE;
            csr_data_in = r_cause;
         end
         c_ST_T_TVAL: begin
            wr_csr_n    = 1'b0;
            csr_wr_addr = c_MTVAL;
            csr_data_in = r_tval;
         end
         c_ST_T_STAT: begin
            wr_csr_n    = 1'b0;
            csr_wr_addr = c_MSTATUS;
            csr_data_in = w_trap_mstatus;
         end
         c_ST_M_STAT: begin
            csr_addr = c_MSTATUS;
         end
         c_ST_M_EPC: begin
            csr_addr = c_MEPC;
         end
         c_ST_M_WR: begin
            wr_csr_n    = 1'b0;
            csr_wr_addr = c_MSTATUS;
            csr_data_in = w_mret_mstatus;
         end
         default: begin
            wr_csr_n = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_funct3         <= 3'b000;
         r_addr           <= 12'h000;
         r_src            <= 32'h0;
         r_idx_zero       <= 1'b0;
         r_old            <= 32'h0;
         r_pc             <= 32'h0;
         r_cause          <= 32'h0;
         r_tval           <= 32'h0;
         r_tvec           <= 32'h0;
         r_st             <= 32'h0;
         r_epc            <= 32'h0;
         r_rd_data        <= 32'h0;
         r_rd_valid       <= 1'b0;
         r_illegal        <= 1'b0;
         r_redirect_pc    <= 32'h0;
         r_redirect_valid <= 1'b0;
      end else begin
         r_rd_valid       <= 1'b0;
         r_illegal        <= 1'b0;
         r_redirect_valid <= 1'b0;
         case (r_state)
            c_ST_IDLE: begin
               if (w_take_trap) begin
                  r_pc    <= trap_pc;
                  r_cause <= trap_cause;
                  r_tval  <= trap_tval;
               end else if (w_take_req) begin
                  r_funct3   <= req_funct3;
                  r_addr     <= req_addr;
                  r_src      <= req_src;
                  r_idx_zero <= req_src_idx_zero;
               end
            end
            c_ST_C_RD: begin
               r_old <= csr_out;
            end
            c_ST_C_WR: begin
               r_rd_valid <= 1'b1;
               r_rd_data  <= r_old;
               r_illegal  <= w_illegal;
            end
            c_ST_T_EPC: begin
               r_tvec <= csr_out;
            end
            c_ST_T_CAUSE: begin
               r_st <= csr_out;
            end
            c_ST_T_STAT: begin
               r_redirect_valid <= 1'b1;
               r_redirect_pc    <= w_trap_target & c_ALIGN_MASK;
            end
            c_ST_M_STAT: begin
               r_st <= csr_out;
            end
            c_ST_M_EPC: begin
               r_epc <= csr_out;
            end
            c_ST_M_WR: begin
               r_redirect_valid <= 1'b1;
               r_redirect_pc    <= r_epc & c_ALIGN_MASK;
            end
            default: begin
               r_rd_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_csr_sequencer.sv
// ==========================================================================
// tb_csr_sequencer : directed self-checking bench with a behavioural CSR file.
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_csr_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_funct3 = 3'b000;
   logic [11:0] req_addr = 12'h000;
   logic [31:0] req_src = 32'h0;
   logic        req_src_idx_zero = 1'b0;
   logic        trap_req = 1'b0;
   logic [31:0] trap_pc = 32'h0;
   logic [31:0] trap_cause = 32'h0;
   logic [31:0] trap_tval = 32'h0;
   logic        mret_req = 1'b0;
   logic [11:0] csr_addr;
   logic [31:0] csr_out;
   logic [11:0] csr_wr_addr;
   logic [31:0] csr_data_in;
   logic        wr_csr_n;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        illegal_csr;
   logic [31:0] redirect_pc;
   logic        redirect_valid;

   int tests = 0;
   int failed = 0;

   always #5 clk = ~clk;

   csr_sequencer #(.RST_PC_ALIGN(2)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_src(req_src), .req_src_idx_zero(req_src_idx_zero),
      .trap_req(trap_req), .trap_pc(trap_pc), .trap_cause(trap_cause),
      .trap_tval(trap_tval), .mret_req(mret_req),
      .csr_addr(csr_addr), .csr_out(csr_out), .csr_wr_addr(csr_wr_addr),
      .csr_data_in(csr_data_in), .wr_csr_n(wr_csr_n),
      .rd_data(rd_data), .rd_valid(rd_valid), .illegal_csr(illegal_csr),
      .redirect_pc(redirect_pc), .redirect_valid(redirect_valid)
   );

   // Behavioural CSR file: combinational read, write on the clock edge.
   logic [31:0] mem [0:4095] = '{default: 32'h0};
   logic [11:0] log_a [0:63];
   logic [31:0] log_d [0:63];
   int          n_wr = 0;
   logic        bd_we = 1'b0;
   logic [11:0] bd_a = 12'h000;
   logic [31:0] bd_d = 32'h0;

   assign csr_out = mem[csr_addr];

   always @(posedge clk) begin
      if (bd_we) mem[bd_a] <= bd_d;
      if (!wr_csr_n) begin
         mem[csr_wr_addr]  <= csr_data_in;
         log_a[n_wr[5:0]]  <= csr_wr_addr;
         log_d[n_wr[5:0]]  <= csr_data_in;
         n_wr              <= n_wr + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic backdoor(input logic [11:0] a, input logic [31:0] d);
      bd_we = 1'b1; bd_a = a; bd_d = d;
      tick();
      bd_we = 1'b0;
   endtask

   // Issues one CSR instruction from IDLE and waits (bounded) for rd_valid.
   task automatic issue_csr(input logic [2:0] f3, input logic [11:0] a,
                            input logic [31:0] s, input logic z,
                            output logic [31:0] rdv, output logic ill,
                            output int lat, output int nw,
                            output logic [11:0] wa, output logic [31:0] wd);
      int w0;
      w0 = n_wr;
      req_valid = 1'b1; req_funct3 = f3; req_addr = a; req_src = s; req_src_idx_zero = z;
      tick();
      req_valid = 1'b0;
      lat = 1;
      while (!rd_valid && lat < 10) begin
         tick();
         lat++;
      end
      rdv = rd_data;
      ill = illegal_csr;
      nw  = n_wr - w0;
      wa  = log_a[w0[5:0]];
      wd  = log_d[w0[5:0]];
   endtask

   task automatic wait_redirect(output int lat);
      lat = 1;
      while (!redirect_valid && lat < 12) begin
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      tests++; if (wr_csr_n !== 1'b1) begin failed++; $display("FAIL reset_wr_csr_n: got %b expected 1", wr_csr_n); end
      tests++; if ({rd_valid, illegal_csr, redirect_valid} !== 3'b000) begin failed++; $display("FAIL reset_pulses: got %b expected 000", {rd_valid, illegal_csr, redirect_valid}); end
      tests++; if (rd_data !== 32'h0 || redirect_pc !== 32'h0) begin failed++; $display("FAIL reset_data: got rd_data=%h redirect_pc=%h expected 0", rd_data, redirect_pc); end
      tests++; if (csr_addr !== 12'h0 || csr_wr_addr !== 12'h0 || csr_data_in !== 32'h0) begin failed++; $display("FAIL reset_csr_ports: got %h %h %h expected 0", csr_addr, csr_wr_addr, csr_data_in); end
      rst = 1'b0;
      #1;
      tests++; if (req_ready !== 1'b1) begin failed++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
   endtask

   task automatic test_rw_rs();
      logic [31:0] rdv, wd; logic [11:0] wa; logic ill; int lat, nw;
      issue_csr(3'b001, 12'h340, 32'hDEAD_BEEF, 1'b0, rdv, ill, lat, nw, wa, wd);
      tests++; if (lat !== 3) begin failed++; $display("FAIL rw_latency: got %0d expected 3", lat); end
      tests++; if (nw !== 1 || wa !== 12'h340 || wd !== 32'hDEAD_BEEF) begin failed++; $display("FAIL rw_write: got n=%0d a=%h d=%h expected 1 340 deadbeef", nw, wa, wd); end
      tests++; if (rdv !== 32'h0 || ill !== 1'b0) begin failed++; $display("FAIL rw_rd: got %h ill=%b expected 0 ill=0", rdv, ill); end
      issue_csr(3'b010, 12'h340, 32'h0, 1'b0, rdv, ill, lat, nw, wa, wd);
      tests++; if (rdv !== 32'hDEAD_BEEF) begin failed++; $display("FAIL b2b_rs_read: got %h expected deadbeef", rdv); end
      tests++; if (nw !== 1 || wd !== 32'hDEAD_BEEF) begin failed++; $display("FAIL b2b_rs_write: got n=%0d d=%h expected 1 deadbeef", nw, wd); end
      tick();
      tests++; if (rd_valid !== 1'b0) begin failed++; $display("FAIL rd_valid_pulse: got %b expected 0", rd_valid); end
   endtask

   task automatic test_set_clear();
      logic [31:0] rdv, wd; logic [11:0] wa; logic ill; int lat, nw;
      backdoor(12'h340, 32'hF0F0_F0F0);
      issue_csr(3'b011, 12'h340, 32'h0000_00FF, 1'b0, rdv, ill, lat, nw, wa, wd);
      tests++; if (nw !== 1 || wd !== 32'hF0F0_F000 || rdv !== 32'hF0F0_F0F0) begin failed++; $display("FAIL rc: got n=%0d d=%h rd=%h expected 1 f0f0f000 f0f0f0f0", nw, wd, rdv); end
      backdoor(12'h340, 32'hF0F0_F0F0);
      issue_csr(3'b010, 12'h340, 32'h0000_0FFF, 1'b1, rdv, ill, lat, nw, wa, wd);
      tests++; if (nw !== 0 || rdv !== 32'hF0F0_F0F0) begin failed++; $display("FAIL rs_x0: got n=%0d rd=%h expected 0 f0f0f0f0", nw, rdv); end
      issue_csr(3'b110, 12'h340, 32'h0000_0005, 1'b0, rdv, ill, lat, nw, wa, wd);
      tests++; if (nw !== 1 || wd !== 32'hF0F0_F0F5) begin failed++; $display("FAIL rsi: got n=%0d d=%h expected 1 f0f0f0f5", nw, wd); end
      issue_csr(3'b111, 12'h340, 32'h0000_0000, 1'b1, rdv, ill, lat, nw, wa, wd);
      tests++; if (nw !== 0 || rdv !== 32'hF0F0_F0F5) begin failed++; $display("FAIL rci_zero: got n=%0d rd=%h expected 0 f0f0f0f5", nw, rdv); end
      issue_csr(3'b101, 12'h341, 32'h0000_001F, 1'b1, rdv, ill, lat, nw, wa, wd);
      tests++; if (nw !== 1 || wa !== 12'h341 || wd !== 32'h0000_001F) begin failed++; $display("FAIL rwi_zero_idx: got n=%0d a=%h d=%h expected 1 341 1f", nw, wa, wd); end
   endtask

   task automatic test_illegal();
      logic [31:0] rdv, wd; logic [11:0] wa; logic ill; int lat, nw;
      backdoor(12'hF11, 32'h0000_0489);
      issue_csr(3'b001, 12'hF11, 32'h1, 1'b0, rdv, ill, lat, nw, wa, wd);
      tests++; if (nw !== 0 || ill !== 1'b1 || rdv !== 32'h0000_0489) begin failed++; $display("FAIL illegal_rw: got n=%0d ill=%b rd=%h expected 0 1 489", nw, ill, rdv); end
      issue_csr(3'b010, 12'hF11, 32'h0, 1'b1, rdv, ill, lat, nw, wa, wd);
      tests++; if (nw !== 0 || ill !== 1'b0 || rdv !== 32'h0000_0489) begin failed++; $display("FAIL ro_read: got n=%0d ill=%b rd=%h expected 0 0 489", nw, ill, rdv); end
   endtask

   task automatic test_trap(input logic [31:0] pc, input logic [31:0] cause,
                            input logic [31:0] tval, input logic [31:0] tvec,
                            input logic [31:0] exp_epc, input logic [31:0] exp_st,
                            input logic [31:0] exp_pc);
      int w0, lat, idx;
      backdoor(12'h305, tvec);
      w0 = n_wr;
      trap_req = 1'b1; trap_pc = pc; trap_cause = cause; trap_tval = tval;
      req_valid = 1'b1; req_funct3 = 3'b001; req_addr = 12'h340; req_src = 32'h1234_5678;
      #1;
      tests++; if (req_ready !== 1'b0) begin failed++; $display("FAIL trap_req_ready: got %b expected 0", req_ready); end
      tick();
      req_valid = 1'b0;
      wait_redirect(lat);
      trap_req = 1'b0;
      tests++; if (lat !== 5 || redirect_pc !== exp_pc) begin failed++; $display("FAIL trap_redirect: got lat=%0d pc=%h expected 5 %h", lat, redirect_pc, exp_pc); end
      tests++; if (n_wr - w0 !== 4) begin failed++; $display("FAIL trap_nwrites: got %0d expected 4", n_wr - w0); end
      idx = w0;
      tests++; if (log_a[idx[5:0]] !== 12'h341 || log_d[idx[5:0]] !== exp_epc) begin failed++; $display("FAIL trap_mepc: got %h=%h expected 341=%h", log_a[idx[5:0]], log_d[idx[5:0]], exp_epc); end
      idx = w0 + 1;
      tests++; if (log_a[idx[5:0]] !== 12'h342 || log_d[idx[5:0]] !== cause) begin failed++; $display("FAIL trap_mcause: got %h=%h expected 342=%h", log_a[idx[5:0]], log_d[idx[5:0]], cause); end
      idx = w0 + 2;
      tests++; if (log_a[idx[5:0]] !== 12'h343 || log_d[idx[5:0]] !== tval) begin failed++; $display("FAIL trap_mtval: got %h=%h expected 343=%h", log_a[idx[5:0]], log_d[idx[5:0]], tval); end
      idx = w0 + 3;
      tests++; if (log_a[idx[5:0]] !== 12'h300 || log_d[idx[5:0]] !== exp_st) begin failed++; $display("FAIL trap_mstatus: got %h=%h expected 300=%h", log_a[idx[5:0]], log_d[idx[5:0]], exp_st); end
      tick();
      tests++; if (redirect_valid !== 1'b0 || req_ready !== 1'b1) begin failed++; $display("FAIL trap_after: got rv=%b ready=%b expected 0 1", redirect_valid, req_ready); end
   endtask

   task automatic test_mret(input logic [31:0] exp_st, input logic [31:0] exp_pc);
      int w0, lat;
      w0 = n_wr;
      mret_req = 1'b1;
      req_valid = 1'b1; req_funct3 = 3'b001; req_addr = 12'h340; req_src = 32'h0;
      #1;
      tests++; if (req_ready !== 1'b0) begin failed++; $display("FAIL mret_req_ready: got %b expected 0", req_ready); end
      tick();
      req_valid = 1'b0;
      wait_redirect(lat);
      mret_req = 1'b0;
      tests++; if (lat !== 4 || redirect_pc !== exp_pc) begin failed++; $display("FAIL mret_redirect: got lat=%0d pc=%h expected 4 %h", lat, redirect_pc, exp_pc); end
      tests++; if (n_wr - w0 !== 1 || log_a[w0[5:0]] !== 12'h300 || log_d[w0[5:0]] !== exp_st) begin failed++; $display("FAIL mret_mstatus: got n=%0d %h=%h expected 1 300=%h", n_wr - w0, log_a[w0[5:0]], log_d[w0[5:0]], exp_st); end
      tick();
   endtask

   task automatic test_reset_mid_trap();
      int w0;
      logic seen_rv;
      trap_req = 1'b1; trap_pc = 32'h400; trap_cause = 32'h5; trap_tval = 32'h0;
      tick();
      tick();
      tests++; if (wr_csr_n !== 1'b0 || csr_wr_addr !== 12'h342) begin failed++; $display("FAIL mid_in_tcause: got n=%b a=%h expected 0 342", wr_csr_n, csr_wr_addr); end
      rst = 1'b1; trap_req = 1'b0;
      tick();
      rst = 1'b0;
      w0 = n_wr;
      #1;
      tests++; if (req_ready !== 1'b1 || wr_csr_n !== 1'b1) begin failed++; $display("FAIL mid_idle: got ready=%b n=%b expected 1 1", req_ready, wr_csr_n); end
      tests++; if (redirect_pc !== 32'h0) begin failed++; $display("FAIL mid_redirect_pc_clear: got %h expected 0", redirect_pc); end
      seen_rv = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         seen_rv = seen_rv | redirect_valid;
      end
      tests++; if (n_wr !== w0 || seen_rv !== 1'b0) begin failed++; $display("FAIL mid_no_more: got writes=%0d rv=%b expected 0 0", n_wr - w0, seen_rv); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_rw_rs();
      test_set_clear();
      test_illegal();
      backdoor(12'h300, 32'h0000_0008);
      test_trap(32'h204, 32'h2, 32'h13, 32'h100, 32'h204, 32'h1880, 32'h100);
      test_mret(32'h1888, 32'h204);
`ifdef CSR_VECTORED_MTVEC_EN
      test_trap(32'h30E, 32'h8000_0007, 32'h0, 32'h101, 32'h30C, 32'h1880, 32'h11C);
`else
      test_trap(32'h30E, 32'h8000_0007, 32'h0, 32'h101, 32'h30C, 32'h1880, 32'h100);
`endif
      test_mret(32'h1888, 32'h30C);
      backdoor(12'h341, 32'h0000_0207);
      test_mret(32'h1888, 32'h204);
      test_reset_mid_trap();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

`default_nettype wire
